serial_master_tx: RTL and testbench

- Master-side serial bus engine that drives the bus the address decoder listens to.
- Accepts a parallel transaction request from the local master (CPU/UART bridge).
- Serialises the device address LSB-first, waits for the decoder ack, then serialises the memory address and, for writes, the write data.
- For reads, collects serial read data from the slave, including slaves that issue split transactions.

---
 rtl/serial_master_tx_if.sv | 34 +++
 rtl/serial_master_tx.sv | 268 ++++++++++++++++++++++++++
 tb/tb_serial_master_tx.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_master_tx_if.sv
// -----------------------------------------------------------------------------
// serial_master_tx_if
// Serial bus between the master engine and the decoder/slave side.
//   mwdata      master -> bus   serial data bit
//   mvalid      master -> bus   serial bit valid
//   mmode       master -> bus   transaction mode (1=write) during MADDR/WDATA
//   ack         bus -> master   decoder acknowledgement of the device address
//   sready      bus -> master   selected slave finished the write
//   srdata      bus -> master   serial read data bit
//   svalid      bus -> master   srdata valid
//   ssplit      bus -> master   slave splits the transaction
//   split_grant bus -> master   arbiter resumes a split transaction
// -----------------------------------------------------------------------------
interface serial_master_tx_if;
    logic mwdata;
    logic mvalid;
    logic mmode;
    logic ack;
    logic sready;
    logic srdata;
    logic svalid;
    logic ssplit;
    logic split_grant;

    modport master (
        output mwdata, mvalid, mmode,
        input  ack, sready, srdata, svalid, ssplit, split_grant
    );

    modport slave (
        input  mwdata, mvalid, mmode,
        output ack, sready, srdata, svalid, ssplit, split_grant
    );
endinterface

// File: rtl/serial_master_tx.sv
// -----------------------------------------------------------------------------
// serial_master_tx
// Master-side serial bus engine. Takes a parallel request from the local
// master, sends the device address LSB-first, waits for the decoder ack,
// sends the memory address (and write data for writes) LSB-first, then waits
// for write completion or collects serial read data. Slaves may split a
// transaction; the engine parks in SPLIT until the arbiter grants it back.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req, wr         request strobe (sampled in IDLE only), 1=write / 0=read
//   dev_addr        target device address
//   mem_addr        address inside the device
//   wdata           write data
//   busy            high in every state except IDLE
//   done, err       one-cycle pulses: successful completion / ack timeout
//   rdata           last read word, held until the next read completes
//   bus             serial bus (master modport)
// -----------------------------------------------------------------------------
module serial_master_tx #(
    parameter int ADDR_WIDTH        = 16,
    parameter int DEVICE_ADDR_WIDTH = 4,
    parameter int MEM_ADDR_WIDTH    = ADDR_WIDTH - DEVICE_ADDR_WIDTH,
    parameter int DATA_WIDTH        = 8,
    parameter int ACK_TIMEOUT       = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req,
    input  logic                         wr,
    input  logic [DEVICE_ADDR_WIDTH-1:0] dev_addr,
    input  logic [MEM_ADDR_WIDTH-1:0]    mem_addr,
    input  logic [DATA_WIDTH-1:0]        wdata,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [DATA_WIDTH-1:0]        rdata,
    serial_master_tx_if.master           bus
);

    // One bit counter serves every serial field, so it is sized for the
    // widest one; the timeout counter counts up to ACK_TIMEOUT-1.
    localparam int MAX_DM = (DEVICE_ADDR_WIDTH > MEM_ADDR_WIDTH) ? DEVICE_ADDR_WIDTH : MEM_ADDR_WIDTH;
    localparam int MAX_W  = (MAX_DM > DATA_WIDTH) ? MAX_DM : DATA_WIDTH;
    localparam int CNT_W  = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam int TMO_W  = $clog2(ACK_TIMEOUT + 1);

    localparam logic [CNT_W-1:0] DEV_LAST  = CNT_W'(DEVICE_ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] MEM_LAST  = CNT_W'(MEM_ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(ACK_TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE, DADDR, ACKW, MADDR, WDATA, CMPL, RWAIT, RDATA, SPLIT
    } state_t;

    state_t                         state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [TMO_W-1:0]               tmo_q, tmo_d;
    logic                           split_rd_q, split_rd_d;   // 1: split came from RWAIT
    logic                           wr_q, wr_d;
    logic [DEVICE_ADDR_WIDTH-1:0]   dev_addr_q, dev_addr_d;
    logic [MEM_ADDR_WIDTH-1:0]      mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]          wdata_q, wdata_d;
    logic [DATA_WIDTH-2:0]          rbuf_q, rbuf_d;           // bits received so far, MSB-aligned
    logic [DATA_WIDTH-1:0]          rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0]          rx_word;
    logic                           done_q, done_d;
    logic                           err_q, err_d;
    logic                           mvalid_q, mvalid_d;
    logic                           mwdata_q, mwdata_d;
    logic                           mmode_q, mmode_d;
    logic [MAX_W-1:0]               dev_pad, mem_pad, wdata_pad;

    // Incoming bit enters at the top; after DATA_WIDTH shifts the first
    // (LSB) bit has reached position 0.
    assign rx_word = {bus.srdata, rbuf_q};

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            tmo_q      <= '0;
            split_rd_q <= 1'b0;
            rdata_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            mvalid_q   <= 1'b0;
            mwdata_q   <= 1'b0;
            mmode_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            split_rd_q <= split_rd_d;
            rdata_q    <= rdata_d;
            done_q     <= done_d;
            err_q      <= err_d;
            mvalid_q   <= mvalid_d;
            mwdata_q   <= mwdata_d;
            mmode_q    <= mmode_d;
        end
    end

    // NOTE: the request payload and the receive shifter are always written
    // before they are read, so they carry no reset.
    always_ff @(posedge clk) begin
        wr_q       <= wr_d;
        dev_addr_q <= dev_addr_d;
        mem_addr_q <= mem_addr_d;
        wdata_q    <= wdata_d;
        rbuf_q     <= rbuf_d;
    end

    // -------------------------------------------------------------------------
    // Next-state logic (state, counters, payload)
    // -------------------------------------------------------------------------
    // NOTE: every variable gets a default at the top of a combinational
    // block, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        split_rd_d = split_rd_q;
        wr_d       = wr_q;
        dev_addr_d = dev_addr_q;
        mem_addr_d = mem_addr_q;
        wdata_d    = wdata_q;
        rbuf_d     = rbuf_q;
        rdata_d    = rdata_q;

        case (state_q)
            IDLE: begin
                // done_q marks the completion cycle; a request there is dropped.
                if (req && !done_q) begin
                    wr_d       = wr;
                    dev_addr_d = dev_addr;
                    mem_addr_d = mem_addr;
                    wdata_d    = wdata;
                    cnt_d      = '0;
                    state_d    = DADDR;
                end
            end
            DADDR: begin
                if (cnt_q == DEV_LAST) begin
                    cnt_d   = '0;
                    tmo_d   = '0;
                    state_d = ACKW;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ACKW: begin
                // ack is tested first so it wins on the expiry cycle.
                if (bus.ack) begin
                    tmo_d   = '0;
                    cnt_d   = '0;
                    state_d = MADDR;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_d   = '0;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            MADDR: begin
                if (cnt_q == MEM_LAST) begin
                    cnt_d   = '0;
                    state_d = wr_q ? WDATA : RWAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WDATA: begin
                if (cnt_q == DATA_LAST) begin
                    cnt_d   = '0;
                    state_d = CMPL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CMPL: begin
                if (bus.sready) begin
                    state_d = IDLE;
                end else if (bus.ssplit) begin
                    split_rd_d = 1'b0;
                    state_d    = SPLIT;
                end
            end
            RWAIT, RDATA: begin
                // A stalled svalid simply holds the counter; split is honoured
                // only before the first bit has arrived.
                if (bus.svalid) begin
                    rbuf_d = rx_word[DATA_WIDTH-1:1];
                    if (cnt_q == DATA_LAST) begin
                        rdata_d = rx_word;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = RDATA;
                    end
                end else if (state_q == RWAIT && bus.ssplit) begin
                    split_rd_d = 1'b1;
                    state_d    = SPLIT;
                end
            end
            SPLIT: begin
                if (bus.split_grant) begin
                    state_d = split_rd_q ? RWAIT : CMPL;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic: computed from the next state so the registered bus
    // outputs line up with the cycle the FSM spends in that state.
    // -------------------------------------------------------------------------
    always_comb begin
        mvalid_d  = 1'b0;
        mwdata_d  = 1'b0;
        mmode_d   = 1'b0;
        dev_pad   = MAX_W'(dev_addr_d);
        mem_pad   = MAX_W'(mem_addr_d);
        wdata_pad = MAX_W'(wdata_d);

        case (state_d)
            DADDR: begin
                mvalid_d = 1'b1;
                mwdata_d = dev_pad[cnt_d];
            end
            MADDR: begin
                mvalid_d = 1'b1;
                mmode_d  = wr_d;
                mwdata_d = mem_pad[cnt_d];
            end
            WDATA: begin
                mvalid_d = 1'b1;
                mmode_d  = wr_d;
                mwdata_d = wdata_pad[cnt_d];
            end
            default: begin
            end
        endcase

        done_d = (state_q == CMPL && bus.sready)
              || ((state_q == RWAIT || state_q == RDATA) && bus.svalid && cnt_q == DATA_LAST);
        err_d  = (state_q == ACKW) && !bus.ack && (tmo_q == TMO_LAST);
    end

    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign err        = err_q;
    assign rdata      = rdata_q;
    assign bus.mvalid = mvalid_q;
    assign bus.mwdata = mwdata_q;
    assign bus.mmode  = mmode_q;

endmodule

// File: tb/tb_serial_master_tx.sv
// -----------------------------------------------------------------------------
// tb_serial_master_tx
// Directed bench for serial_master_tx: write, read with ack on the timeout
// boundary, ack timeout, split read, reset mid-transaction, and requests
// arriving while busy or on the completion cycle.
// -----------------------------------------------------------------------------
module tb_serial_master_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        wr;
    logic [3:0]  dev_addr;
    logic [11:0] mem_addr;
    logic [7:0]  wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  rdata;

    int tests    = 0;
    int fails    = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    serial_master_tx_if bus_if ();

    serial_master_tx dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .wr       (wr),
        .dev_addr (dev_addr),
        .mem_addr (mem_addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .rdata    (rdata),
        .bus      (bus_if)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (err)  err_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, observed timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_txn(input logic w, input logic [3:0] d, input logic [11:0] m, input logic [7:0] wd);
        wr       = w;
        dev_addr = d;
        mem_addr = m;
        wdata    = wd;
        req      = 1'b1;
        step();
        req      = 1'b0;
    endtask

    // Observe n cycles: serial bits (first bit -> bit 0), mvalid/mmode/busy counts.
    task automatic collect(input int n, output logic [31:0] bits, output int nv,
                           output int nm, output int nb);
        bits = '0;
        nv = 0;
        nm = 0;
        nb = 0;
        for (int i = 0; i < n; i++) begin
            bits = bits | (32'(bus_if.mwdata) << i);
            if (bus_if.mvalid) nv++;
            if (bus_if.mmode)  nm++;
            if (busy)          nb++;
            step();
        end
    endtask

    // Slave returns a word LSB-first; before bit stall_at, svalid drops for
    // stall_len cycles (with ssplit raised if probe is set). Counts mvalid.
    task automatic send_word(input logic [7:0] val, input int stall_at, input int stall_len,
                             input logic probe, output int nv);
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == stall_at) begin
                bus_if.svalid = 1'b0;
                bus_if.ssplit = probe;
                for (int k = 0; k < stall_len; k++) begin
                    if (bus_if.mvalid) nv++;
                    step();
                end
                bus_if.ssplit = 1'b0;
            end
            bus_if.svalid = 1'b1;
            bus_if.srdata = val[i];
            if (bus_if.mvalid) nv++;
            step();
        end
        bus_if.svalid = 1'b0;
        bus_if.srdata = 1'b0;
    endtask

    logic [31:0] bits;
    int nv, nm, nb, d0, e0;

    initial begin
        rst = 1'b1; req = 1'b0; wr = 1'b0;
        dev_addr = '0; mem_addr = '0; wdata = '0;
        bus_if.ack = 1'b0; bus_if.sready = 1'b0; bus_if.srdata = 1'b0;
        bus_if.svalid = 1'b0; bus_if.ssplit = 1'b0; bus_if.split_grant = 1'b0;
        step(2);
        rst = 1'b0;

        // ---- reset state ----
        check("rst_busy",   busy, 0);
        check("rst_done",   done, 0);
        check("rst_err",    err, 0);
        check("rst_mvalid", bus_if.mvalid, 0);
        check("rst_mwdata", bus_if.mwdata, 0);
        check("rst_mmode",  bus_if.mmode, 0);
        check("rst_rdata",  rdata, 0);

        // ---- write: dev 1, mem A5C, data 3C, ack in first ACKW cycle ----
        d0 = done_cnt;
        start_txn(1'b1, 4'h1, 12'hA5C, 8'h3C);
        collect(4, bits, nv, nm, nb);
        check("wr_dev_bits", bits, 32'h1);
        check("wr_dev_valid", nv, 4);
        check("wr_dev_mode", nm, 0);
        check("wr_ackw_gap", bus_if.mvalid, 0);
        check("wr_ackw_busy", busy, 1);
        bus_if.ack = 1'b1;
        step();
        bus_if.ack = 1'b0;
        collect(12, bits, nv, nm, nb);
        check("wr_mem_bits", bits, 32'hA5C);
        check("wr_mem_valid", nv, 12);
        check("wr_mem_mode", nm, 12);
        collect(8, bits, nv, nm, nb);
        check("wr_data_bits", bits, 32'h3C);
        check("wr_data_valid", nv, 8);
        check("wr_data_mode", nm, 8);
        check("wr_cmpl_mvalid", bus_if.mvalid, 0);
        step(3);
        check("wr_cmpl_busy", busy, 1);
        check("wr_cmpl_nodone", done, 0);
        bus_if.sready = 1'b1;
        step();
        bus_if.sready = 1'b0;
        check("wr_done", done, 1);
        check("wr_idle", busy, 0);
        step();
        check("wr_done_pulse", done, 0);
        check("wr_done_count", done_cnt - d0, 1);

        // ---- read: dev 0, mem 001, ack on the last ACKW cycle, data A7 ----
        d0 = done_cnt;
        e0 = err_cnt;
        start_txn(1'b0, 4'h0, 12'h001, 8'h00);
        collect(4, bits, nv, nm, nb);
        check("rd_dev_bits", bits, 32'h0);
        step(15);
        check("rd_ackw_busy", busy, 1);
        bus_if.ack = 1'b1;
        step();
        bus_if.ack = 1'b0;
        collect(12, bits, nv, nm, nb);
        check("rd_mem_bits", bits, 32'h001);
        check("rd_mem_valid", nv, 12);
        check("rd_mem_mode", nm, 0);
        check("rd_no_err", err_cnt - e0, 0);
        send_word(8'hA7, 4, 2, 1'b0, nv);
        check("rd_phase_mvalid", nv, 0);
        check("rd_done", done, 1);
        check("rd_rdata", rdata, 8'hA7);
        check("rd_idle", busy, 0);
        step();
        check("rd_rdata_hold", rdata, 8'hA7);
        check("rd_done_count", done_cnt - d0, 1);

        // ---- ack timeout: dev 3, ack never comes ----
        d0 = done_cnt;
        e0 = err_cnt;
        start_txn(1'b1, 4'h3, 12'h0AB, 8'h11);
        collect(4, bits, nv, nm, nb);
        check("to_dev_bits", bits, 32'h3);
        collect(15, bits, nv, nm, nb);
        check("to_ackw_mvalid", nv, 0);
        check("to_ackw_busy", nb, 15);
        check("to_no_early_err", err, 0);
        step();
        check("to_err", err, 1);
        step();
        check("to_err_pulse", err, 0);
        check("to_idle", busy, 0);
        check("to_no_maddr", bus_if.mvalid, 0);
        check("to_err_count", err_cnt - e0, 1);
        check("to_no_done", done_cnt - d0, 0);

        // ---- split read: dev 2, split in RWAIT, grant 20 cycles later, 5E ----
        d0 = done_cnt;
        start_txn(1'b0, 4'h2, 12'h0F0, 8'h00);
        step(4);
        bus_if.ack = 1'b1;
        step();
        bus_if.ack = 1'b0;
        step(12);
        bus_if.ssplit = 1'b1;
        step();
        bus_if.ssplit = 1'b0;
        collect(19, bits, nv, nm, nb);
        check("sp_busy", nb, 19);
        check("sp_mvalid", nv, 0);
        check("sp_busy_grant", busy, 1);
        bus_if.split_grant = 1'b1;
        step();
        bus_if.split_grant = 1'b0;
        // ssplit after the first bits must be ignored.
        send_word(8'h5E, 2, 1, 1'b1, nv);
        check("sp_done", done, 1);
        check("sp_rdata", rdata, 8'h5E);
        step();
        check("sp_done_count", done_cnt - d0, 1);

        // ---- reset after 5 MADDR bits ----
        d0 = done_cnt;
        e0 = err_cnt;
        start_txn(1'b1, 4'h1, 12'h123, 8'h55);
        step(4);
        bus_if.ack = 1'b1;
        step();
        bus_if.ack = 1'b0;
        collect(5, bits, nv, nm, nb);
        check("rs_mem_bits", bits, 32'h03);
        check("rs_mem_valid", nv, 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rs_mvalid", bus_if.mvalid, 0);
        check("rs_busy", busy, 0);
        step(3);
        check("rs_quiet", bus_if.mvalid, 0);
        check("rs_no_done", done_cnt - d0, 0);
        check("rs_no_err", err_cnt - e0, 0);

        // ---- following write; req during CMPL and on the done cycle ----
        start_txn(1'b1, 4'h5, 12'h3C1, 8'hC3);
        collect(4, bits, nv, nm, nb);
        check("fw_dev_bits", bits, 32'h5);
        bus_if.ack = 1'b1;
        step();
        bus_if.ack = 1'b0;
        collect(12, bits, nv, nm, nb);
        check("fw_mem_bits", bits, 32'h3C1);
        collect(8, bits, nv, nm, nb);
        check("fw_data_bits", bits, 32'hC3);
        wr = 1'b0;
        dev_addr = 4'hF;
        req = 1'b1;
        step();
        req = 1'b0;
        check("fw_cmpl_busy", busy, 1);
        check("fw_cmpl_mvalid", bus_if.mvalid, 0);
        bus_if.sready = 1'b1;
        step();
        bus_if.sready = 1'b0;
        check("fw_done", done, 1);
        req = 1'b1;
        step();
        req = 1'b0;
        check("fw_req_on_done", busy, 0);
        check("fw_no_bits", bus_if.mvalid, 0);
        step(2);
        check("fw_still_idle", busy, 0);
        check("fw_done_count", done_cnt - d0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
